enc_binder_array: RTL and testbench
===================================

# enc_binder_array

Parametrised, time-multiplexed binding stage for the sparse HDC encoder. It captures NUM_CH level hypervectors on a start pulse and circularly rotates each one by its per-channel amount, SHIFTS[BASE_IDX+ch]. The work runs through LANES shared runtime rotators, one group per cycle, so area is traded against latency. It replaces fixed-count binder packs and adds an unbind (inverse-rotation) mode and a busy/done handshake for the encoder controller.

## Interface
- HV_DIM, default hdc_pkg::HV_DIM: hypervector width in bits.
- NUM_CH, default 10: number of channels bound per run.
- LANES, default 2: number of physical rotators. Legal range is 1..NUM_CH.
- BASE_IDX, default 0: first index into hdc_pkg::SHIFTS. BASE_IDX+NUM_CH must not exceed the SHIFTS length.
- clk, input, 1: sole clock, rising edge.
- nrst, input, 1: asynchronous active-low reset.
- start_encoding, input, 1: run request. Sampled only in IDLE.
- unbind, input, 1: captured with start. 0 = bind (rotate left), 1 = unbind (rotate right).
- level_hv, input, [NUM_CH] x HV_DIM: per-channel level HVs. Captured on the accepted start edge.
- shifted_hv, output, [NUM_CH] x HV_DIM: bound HVs. Registered and held between runs.
- busy, output, 1: high while a run is in progress.
- done, output, 1: single-cycle pulse when all channels have been written.

## Operation
- G = ceil(NUM_CH/LANES) groups per run. Channel ch belongs to group ch/LANES and uses lane ch%LANES.
- FSM states:
  - IDLE:
    - start_encoding=1 → capture level_hv into the input buffer, latch unbind, grp←0, busy←1, go to RUN.
    - start_encoding=0 → stay in IDLE.
  - RUN: each cycle, write the rotator outputs of group grp into the matching shifted_hv entries, then grp←grp+1.
    - On the write of group G-1: busy←0, done←1, go to IDLE.
    - Lanes whose channel index is ≥NUM_CH in the last partial group are gated; no write.
- Rotation amount s = SHIFTS[BASE_IDX+ch] mod HV_DIM, a compile-time constant per channel, selected by grp at runtime.
- Rotation direction:
  - Bind: out[(j+s) mod HV_DIM] = in[j].
  - Unbind: out[j] = in[(j+s) mod HV_DIM].
  - s=0 is identity.
- Channels not yet written in the current run keep their previous-run values.
- start_encoding while busy is ignored. No queuing, no error.
- level_hv changes after the accepted start edge have no effect on the current run.

## Timing
- Reset, asynchronous: state=IDLE, grp=0, busy=0, done=0, all shifted_hv=0, input buffer=0.
- Accepted start at edge E0:
  - Group k is written at edge E0+1+k.
  - The last group is written at edge E0+G; done is high for one cycle after E0+G.
  - busy is high from E0 until E0+G.
- A new start is accepted at edge E0+G+1 at the earliest, i.e. the cycle done is high. Back-to-back period is G+1 cycles.
- nrst asserted mid-run: the run aborts immediately, there is no done pulse, and the reset values apply. The first start after nrst is released begins a fresh run.
- LANES=NUM_CH gives G=1: done follows start by one edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- hdc_pkg holds:
  - HV_DIM
  - the SHIFTS constant array
  - the FSM state enum (IDLE, RUN)
  - helper function ceil_div
- One sub-module, hv_rotator: combinational, parameter HV_DIM, inputs in, amt [$clog2(HV_DIM)], dir; output out. It is instantiated LANES times.
- The per-lane amount mux is a constant table indexed by grp, built at elaboration from SHIFTS.
- Elaboration-time asserts cover the LANES range and the SHIFTS index range.

## Test plan
- Reset: hold nrst=0 with random inputs → shifted_hv all 0, busy=0, done=0. No activity after release until start.
- Bind, NUM_CH=10, LANES=4 (G=3): level_hv[ch]=one-hot bit 0, start at E0. Required response:
  - shifted_hv[ch] has only bit SHIFTS[BASE_IDX+ch] mod HV_DIM set.
  - Channels 0-3 written at E0+1, 4-7 at E0+2, 8-9 at E0+3.
  - done pulses exactly once after E0+3.
- Unbind round trip: bind random HVs, feed the outputs back with unbind=1 → shifted_hv equals the original level_hv bit-exactly for all channels.
- Start while busy: pulse start at E0+1 and E0+2 with new data → ignored; outputs match the E0 data; one done only.
- Reset mid-run: assert nrst between E0+1 and E0+2 → all outputs 0 immediately, no done. A fresh run after release completes in G+1 cycles.
- Edge configurations, each matching the reference model:
  - LANES=1, NUM_CH=10: 10 write cycles, done after E0+10.
  - LANES=NUM_CH: done after E0+1.
  - A channel with SHIFTS entry ≥HV_DIM: wraps mod HV_DIM.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared HDC encoder constants, FSM state type and elaboration helpers
package hdc_pkg;
  localparam int HV_DIM = 64;
  localparam int NUM_SHIFTS = 16;
  // Several entries exceed HV_DIM on purpose; consumers reduce them mod HV_DIM
  localparam int SHIFTS [NUM_SHIFTS] = '{0, 1, 5, 13, 63, 64, 70, 127, 200, 31, 7, 2, 33, 45, 100, 9};
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/hv_rotator.sv
// hv_rotator: combinational circular rotate, dir=0 left (bind), dir=1 right (unbind)
module hv_rotator #(
  parameter int HV_DIM = 64
) (
  input  logic [HV_DIM-1:0]         in,
  input  logic [$clog2(HV_DIM)-1:0] amt,
  input  logic                      dir,
  output logic [HV_DIM-1:0]         out
);
  localparam int AW = $clog2(HV_DIM);
  logic [2*HV_DIM-1:0] w_dbl;
  logic [AW:0]         w_base;
  assign w_dbl  = {in, in};
  // A left rotate by s is a window starting at HV_DIM-s of the doubled word
  assign w_base = dir ? {1'b0, amt} : (AW+1)'(HV_DIM) - {1'b0, amt};
  assign out    = w_dbl[w_base +: HV_DIM];
endmodule

// File: rtl/enc_binder_array.sv
// enc_binder_array: time-multiplexed bind/unbind of NUM_CH hypervectors over LANES rotators
module enc_binder_array #(
  parameter int HV_DIM   = hdc_pkg::HV_DIM,
  parameter int NUM_CH   = 10,
  parameter int LANES    = 2,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              unbind,
  input  logic [HV_DIM-1:0] level_hv   [NUM_CH],
  output logic [HV_DIM-1:0] shifted_hv [NUM_CH],
  output logic              busy,
  output logic              done
);
  import hdc_pkg::*;
  localparam int G  = ceil_div(NUM_CH, LANES);
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int GN = 2 ** GW;
  localparam int AW = $clog2(HV_DIM);
  if (LANES < 1 || LANES > NUM_CH) begin : g_bad_lanes
    $error("enc_binder_array: LANES must lie in 1..NUM_CH");
  end
  if (BASE_IDX < 0 || BASE_IDX + NUM_CH > NUM_SHIFTS) begin : g_bad_idx
    $error("enc_binder_array: BASE_IDX+NUM_CH exceeds SHIFTS");
  end
  state_t            r_state, w_next;
  logic [GW-1:0]     r_grp;
  logic              r_unbind, r_done, w_last;
  logic [HV_DIM-1:0] r_buf [NUM_CH];
  logic [HV_DIM-1:0] r_out [NUM_CH];
  logic [HV_DIM-1:0] w_rot [LANES];
  assign w_last = r_grp == GW'(G - 1);
  genvar l, g;
  for (l = 0; l < LANES; l++) begin : g_lane
    logic [AW-1:0]     w_amt_tbl [GN];
    logic [HV_DIM-1:0] w_in_tbl  [GN];
    // Per-lane constant tables indexed by group; slots past NUM_CH feed zeros
    for (g = 0; g < GN; g++) begin : g_grp
      localparam int CH = g * LANES + l;
      if (g < G && CH < NUM_CH) begin : g_live
        assign w_amt_tbl[g] = AW'(SHIFTS[BASE_IDX + CH] % HV_DIM);
        assign w_in_tbl[g]  = r_buf[CH];
      end else begin : g_gate
        assign w_amt_tbl[g] = '0;
        assign w_in_tbl[g]  = '0;
      end
    end
    hv_rotator #(.HV_DIM(HV_DIM)) u_rot (
      .in  (w_in_tbl[r_grp]),
      .amt (w_amt_tbl[r_grp]),
      .dir (r_unbind),
      .out (w_rot[l])
    );
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (start_encoding ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_grp    <= '0;
      r_unbind <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_buf[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_done <= r_state == RUN && w_last;
      if (r_state == IDLE) begin
        r_grp <= '0;
        if (start_encoding) begin
          r_buf    <= level_hv;
          r_unbind <= unbind;
        end
      end else begin
        r_grp <= w_last ? '0 : r_grp + 1'b1;
        for (int c = 0; c < NUM_CH; c++)
          if (r_grp == GW'(c / LANES)) r_out[c] <= w_rot[c % LANES];
      end
    end
  end
  assign busy       = r_state == RUN;
  assign done       = r_done;
  assign shifted_hv = r_out;
endmodule

// File: tb/tb_enc_binder_array.sv
// tb_enc_binder_array: randomized bind/unbind runs on three lane configurations against a bit-level rotation model
module tb_enc_binder_array;
  import hdc_pkg::*;
  localparam int N  = HV_DIM;
  localparam int NC = 10;
  localparam int LN [3] = '{4, 1, 10};
  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          unb = 1'b0;
  logic [2:0]    st = '0;
  logic [2:0]    bz, dn;
  logic [N-1:0]  lvl [NC];
  logic [N-1:0]  sh0 [NC];
  logic [N-1:0]  sh1 [NC];
  logic [N-1:0]  sh2 [NC];
  logic [N-1:0]  mdl [3][NC];
  logic [N-1:0]  orig [NC];
  int            errs = 0;
  int            checks = 0;
  always #5 clk = ~clk;
  enc_binder_array #(.HV_DIM(N), .NUM_CH(NC), .LANES(4), .BASE_IDX(0)) u0 (
    .clk(clk), .nrst(nrst), .start_encoding(st[0]), .unbind(unb),
    .level_hv(lvl), .shifted_hv(sh0), .busy(bz[0]), .done(dn[0]));
  enc_binder_array #(.HV_DIM(N), .NUM_CH(NC), .LANES(1), .BASE_IDX(0)) u1 (
    .clk(clk), .nrst(nrst), .start_encoding(st[1]), .unbind(unb),
    .level_hv(lvl), .shifted_hv(sh1), .busy(bz[1]), .done(dn[1]));
  enc_binder_array #(.HV_DIM(N), .NUM_CH(NC), .LANES(10), .BASE_IDX(0)) u2 (
    .clk(clk), .nrst(nrst), .start_encoding(st[2]), .unbind(unb),
    .level_hv(lvl), .shifted_hv(sh2), .busy(bz[2]), .done(dn[2]));
  function automatic logic [N-1:0] rot(logic [N-1:0] v, int s, bit u);
    logic [N-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (u) r[j] = v[(j + s) % N];
      else r[(j + s) % N] = v[j];
    return r;
  endfunction
  function automatic logic [N-1:0] rd(int d, int c);
    return d == 0 ? sh0[c] : d == 1 ? sh1[c] : sh2[c];
  endfunction
  task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] want);
    checks++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask
  task automatic check_state(string tag, logic [2:0] eb, logic [2:0] ed);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NC; c++)
        chk($sformatf("%s d%0d ch%0d", tag, d, c), rd(d, c), mdl[d][c]);
    chk({tag, " busy"}, N'(bz), N'(eb));
    chk({tag, " done"}, N'(dn), N'(ed));
  endtask
  task automatic zero_model();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NC; c++) mdl[d][c] = '0;
  endtask
  task automatic rand_lvl();
    for (int c = 0; c < NC; c++) lvl[c] = N'({$urandom, $urandom});
  endtask
  // One run on DUT d; noise re-pulses start with fresh data while it is busy
  task automatic run(int d, bit u, bit rnd, bit noise);
    logic [N-1:0] nxt [NC];
    int g = (NC + LN[d] - 1) / LN[d];
    @(negedge clk);
    if (rnd) rand_lvl();
    unb = u;
    st[d] = 1'b1;
    for (int c = 0; c < NC; c++) nxt[c] = rot(lvl[c], SHIFTS[c] % N, u);
    @(posedge clk); #1;
    st[d] = 1'b0;
    check_state($sformatf("d%0d E0", d), 3'(1 << d), 3'b000);
    for (int k = 1; k <= g; k++) begin
      @(negedge clk);
      if (noise && k <= 2) begin
        st[d] = 1'b1;
        unb = ~u;
        rand_lvl();
      end
      @(posedge clk); #1;
      st[d] = 1'b0;
      for (int c = 0; c < NC; c++) if (c / LN[d] == k - 1) mdl[d][c] = nxt[c];
      check_state($sformatf("d%0d E0+%0d", d, k), k < g ? 3'(1 << d) : 3'b000, k == g ? 3'(1 << d) : 3'b000);
    end
    @(posedge clk); #1;
    check_state($sformatf("d%0d after", d), 3'b000, 3'b000);
  endtask
  initial begin
    zero_model();
    rand_lvl();
    st = 3'b111;
    unb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 3'b000, 3'b000);
    @(negedge clk);
    nrst = 1'b1;
    st = '0;
    repeat (3) @(posedge clk);
    #1;
    check_state("idle", 3'b000, 3'b000);
    for (int c = 0; c < NC; c++) lvl[c] = N'(1);
    run(0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk($sformatf("onehot ch%0d", c), sh0[c], N'(1) << (SHIFTS[c] % N));
    run(0, 1'b0, 1'b1, 1'b0);
    orig = lvl;
    lvl = sh0;
    run(0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk($sformatf("roundtrip ch%0d", c), sh0[c], orig[c]);
    run(0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rand_lvl();
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    zero_model();
    check_state("midreset", 3'b000, 3'b000);
    @(posedge clk); #1;
    check_state("midreset hold", 3'b000, 3'b000);
    @(negedge clk);
    nrst = 1'b1;
    run(0, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
